// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, R-type functs,
// FSM state type and ALU operation type.
package mips_mc_pkg;

  localparam logic [2:0] OpRtype = 3'b000;
  localparam logic [2:0] OpSlti  = 3'b001;
  localparam logic [2:0] OpJ     = 3'b010;
  localparam logic [2:0] OpJal   = 3'b011;
  localparam logic [2:0] OpLw    = 3'b100;
  localparam logic [2:0] OpSw    = 3'b101;
  localparam logic [2:0] OpBeq   = 3'b110;
  localparam logic [2:0] OpAddi  = 3'b111;

  localparam logic [3:0] FnAdd = 4'd0;
  localparam logic [3:0] FnSub = 4'd1;
  localparam logic [3:0] FnAnd = 4'd2;
  localparam logic [3:0] FnOr  = 4'd3;
  localparam logic [3:0] FnSlt = 4'd4;
  localparam logic [3:0] FnJr  = 4'd8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // Unknown R-type functs fall back to add; beq compares by subtraction.
  function automatic alu_op_e alu_op_decode(logic [2:0] opcode, logic [3:0] funct);
    alu_op_e op;
    op = AluAdd;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd:   op = AluAdd;
          FnSub:   op = AluSub;
          FnAnd:   op = AluAnd;
          FnOr:    op = AluOr;
          FnSlt:   op = AluSlt;
          default: op = AluAdd;
        endcase
      end
      OpSlti:  op = AluSlt;
      OpBeq:   op = AluSub;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_multicycle_if.sv
// Instruction and data memory req/ready ports of the multi-cycle MIPS core.
// master = core side, slave = memory side.
interface mips_multicycle_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_ready;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/mips_mc_regfile.sv
// 8 x DATA_W register file: two asynchronous read ports, one synchronous
// write port, cleared on reset. r0 reads as zero and ignores writes.
module mips_mc_regfile #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [2:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [8];

  // Register storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '{default: '0};
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 3'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 3'd0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle 16-bit-ISA MIPS core with a DATA_W-wide datapath and stallable
// instruction/data memory ports. Defining MIPS_MC_PERF_EN adds a 32-bit
// retired-instruction counter on the instret port.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  mips_multicycle_if.master bus,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              retire
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]       instret
`endif
);

  state_e            state_q;
  logic [DATA_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0] daddr_q, dwdata_q;
  logic              imem_req_q, dmem_req_q, dmem_we_q, retire_q;

  // Instruction fields
  logic [2:0]  opcode, rs, rt, rd;
  logic [3:0]  funct;
  logic [6:0]  imm7;
  logic [12:0] jtarget;

  assign opcode  = ir_q[15:13];
  assign rs      = ir_q[12:10];
  assign rt      = ir_q[9:7];
  assign rd      = ir_q[6:4];
  assign funct   = ir_q[3:0];
  assign imm7    = ir_q[6:0];
  assign jtarget = ir_q[12:0];

  logic [DATA_W-1:0] imm_ext, alu_b, alu_y, pc_plus2, br_target, j_target;
  logic              is_jr;
  alu_op_e           alu_op;

  // slti compares against an unsigned immediate; everything else sign-extends.
  assign imm_ext   = (opcode == OpSlti) ? {{(DATA_W-7){1'b0}}, imm7}
                                        : {{(DATA_W-7){imm7[6]}}, imm7};
  assign alu_b     = ((opcode == OpRtype) || (opcode == OpBeq)) ? b_q : imm_ext;
  assign alu_op    = alu_op_decode(opcode, funct);
  assign pc_plus2  = pc_q + DATA_W'(2);
  assign br_target = pc_plus2 + (imm_ext << 1);
  assign j_target  = {pc_plus2[DATA_W-1:14], jtarget, 1'b0};
  assign is_jr     = (opcode == OpRtype) && (funct == FnJr);

  // ALU
  always_comb begin
    alu_y = '0;
    case (alu_op)
      AluAdd:  alu_y = a_q + alu_b;
      AluSub:  alu_y = a_q - alu_b;
      AluAnd:  alu_y = a_q & alu_b;
      AluOr:   alu_y = a_q | alu_b;
      AluSlt:  alu_y = {{(DATA_W-1){1'b0}}, (a_q < alu_b)};
      default: alu_y = a_q + alu_b;
    endcase
  end

  // Register file write port: WB for results/loads, EXEC for the jal link.
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_q;
    if ((state_q == StExec) && (opcode == OpJal)) begin
      rf_we    = 1'b1;
      rf_waddr = 3'd7;
      rf_wdata = pc_plus2;
    end else if (state_q == StWb) begin
      rf_we    = 1'b1;
      rf_waddr = (opcode == OpRtype) ? rd : rt;
      rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;
    end
  end

  mips_mc_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .raddr_a_i (rs),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rt),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  // Control FSM; request, retire and bus outputs are registered with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      retire_q   <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (bus.imem_ready) begin
            ir_q       <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= rf_rdata_a;
          b_q     <= rf_rdata_b;
          state_q <= StExec;
        end
        StExec: begin
          alu_q <= alu_y;
          case (opcode)
            OpLw, OpSw: begin
              daddr_q    <= alu_y;
              dwdata_q   <= b_q;
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (opcode == OpSw);
              state_q    <= StMem;
            end
            OpBeq: begin
              pc_q       <= (alu_y == '0) ? br_target : pc_plus2;
              imem_req_q <= 1'b1;
              retire_q   <= 1'b1;
              state_q    <= StFetch;
            end
            OpJ, OpJal: begin
              pc_q       <= j_target;
              imem_req_q <= 1'b1;
              retire_q   <= 1'b1;
              state_q    <= StFetch;
            end
            default: begin
              if (is_jr) begin
                pc_q       <= a_q;
                imem_req_q <= 1'b1;
                retire_q   <= 1'b1;
                state_q    <= StFetch;
              end else begin
                state_q <= StWb;
              end
            end
          endcase
        end
        StMem: begin
          if (bus.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (opcode == OpSw) begin
              pc_q       <= pc_plus2;
              imem_req_q <= 1'b1;
              retire_q   <= 1'b1;
              state_q    <= StFetch;
            end else begin
              mdr_q   <= bus.dmem_rdata;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          pc_q       <= pc_plus2;
          imem_req_q <= 1'b1;
          retire_q   <= 1'b1;
          state_q    <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = daddr_q;
  assign bus.dmem_wdata = dwdata_q;
  assign pc_out         = pc_q;
  assign alu_result     = alu_q;
  assign retire         = retire_q;

`ifdef MIPS_MC_PERF_EN
  logic [31:0] instret_q;

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
    end else if (retire_q) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: per-retire PC/ALU/cycle expectations
// and per-access data-memory expectations, plus reset and abort checks.
module tb_mips_multicycle;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_if #(.DATA_W(DW)) bus ();

  logic [DW-1:0] pc_out, alu_result;
  logic          retire;
`ifdef MIPS_MC_PERF_EN
  logic [31:0]   instret;
`endif

  mips_multicycle #(
    .DATA_W   (DW),
    .RESET_PC ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .retire     (retire)
`ifdef MIPS_MC_PERF_EN
    ,
    .instret    (instret)
`endif
  );

  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] alu;
    bit            chk_alu;
    int            gap;
  } ret_exp_t;

  typedef struct {
    bit            we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cycles;
  } mem_exp_t;

  ret_exp_t ret_q[$];
  mem_exp_t mem_q[$];

  logic [15:0]   imem [64];
  logic [DW-1:0] dmem [64];
  int            istall [64];
  int            dstall [64];

  int tests_run = 0;
  int tests_failed = 0;
  bit sb_on = 1'b0;
  int cyc = 0;
  int last_ret = 0;
  int ret_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_ret(input logic [DW-1:0] pc, input logic [DW-1:0] alu, input bit chk,
                          input int gap);
    ret_exp_t e;
    e.pc = pc; e.alu = alu; e.chk_alu = chk; e.gap = gap;
    ret_q.push_back(e);
  endtask

  task automatic push_mem(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input int cycles);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.cycles = cycles;
    mem_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (ret_q.size() != 0 || mem_q.size() != 0); i++) @(posedge clk);
    check({tag, "_ret_left"}, ret_q.size(), 0);
    check({tag, "_mem_left"}, mem_q.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Store completes only on a real handshake edge (reset low forces req low).
  bit            st_fire = 1'b0;
  logic [DW-1:0] st_addr, st_data;
  always @(posedge clk) begin
    st_fire <= bus.dmem_req && bus.dmem_ready && bus.dmem_we;
    st_addr <= bus.dmem_addr;
    st_data <= bus.dmem_wdata;
  end

  // Retire monitor: pop expectation and compare PC, ALU result and spacing.
  ret_exp_t re;
  always @(negedge clk) begin
    if (retire) begin
      if (sb_on) begin
        check("retire_expected", ret_q.size() != 0, 1);
        if (ret_q.size() != 0) begin
          re = ret_q.pop_front();
          check("retire_pc", pc_out, re.pc);
          if (re.chk_alu) check("retire_alu", alu_result, re.alu);
          if (re.gap > 0) check("retire_gap", cyc - last_ret, re.gap);
        end
      end
      last_ret = cyc;
      ret_cnt  = ret_cnt + 1;
    end
  end

  // Memory responders with per-address wait states; data side is scoreboarded.
  bit       i_act = 1'b0, d_act = 1'b0, d_have = 1'b0;
  int       i_left = 0, d_left = 0, d_cyc = 0;
  mem_exp_t d_exp;
  always @(negedge clk) begin
    if (st_fire) dmem[st_addr[6:1]] = st_data;
    st_fire = 1'b0;

    if (bus.imem_req) begin
      if (!i_act) begin
        i_act  = 1'b1;
        i_left = istall[bus.imem_addr[6:1]];
      end
      if (i_left > 0) begin
        bus.imem_ready = 1'b0;
        i_left = i_left - 1;
      end else begin
        bus.imem_ready = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr[6:1]];
        i_act = 1'b0;
      end
    end else begin
      bus.imem_ready = 1'b1;
      i_act = 1'b0;
    end

    if (bus.dmem_req) begin
      if (!d_act) begin
        d_act  = 1'b1;
        d_left = dstall[bus.dmem_addr[6:1]];
        d_cyc  = 0;
        d_have = 1'b0;
        if (sb_on) begin
          check("dmem_expected", mem_q.size() != 0, 1);
          if (mem_q.size() != 0) begin
            d_exp  = mem_q.pop_front();
            d_have = 1'b1;
          end
        end
      end
      d_cyc = d_cyc + 1;
      if (d_have) begin
        check("dmem_addr", bus.dmem_addr, d_exp.addr);
        check("dmem_we", bus.dmem_we, d_exp.we);
        if (d_exp.we) check("dmem_wdata", bus.dmem_wdata, d_exp.wdata);
      end
      if (d_left > 0) begin
        bus.dmem_ready = 1'b0;
        d_left = d_left - 1;
      end else begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = dmem[bus.dmem_addr[6:1]];
        d_act = 1'b0;
        if (d_have) check("dmem_req_cycles", d_cyc, d_exp.cycles);
      end
    end else begin
      bus.dmem_ready = 1'b1;
      d_act = 1'b0;
    end
  end

  bit found;
  int ret_base;

  initial begin
    for (int i = 0; i < 64; i++) begin
      imem[i] = '0; dmem[i] = '0; istall[i] = 0; dstall[i] = 0;
    end
    imem[0]  = 16'hE185; // addi r3,r0,5
    imem[1]  = 16'h0DC0; // add  r4,r3,r3
    imem[2]  = 16'h6008; // jal  0x10
    imem[3]  = 16'hC07F; // beq  r0,r0,-1 (loop at 6)
    imem[8]  = 16'h8184; // lw   r3,4(r0)
    imem[9]  = 16'h0FD0; // add  r5,r3,r7
    imem[10] = 16'h11E1; // sub  r6,r4,r3
    imem[11] = 16'h38FF; // slti r1,r6,0x7f
    imem[12] = 16'h0324; // slt  r2,r0,r6
    imem[13] = 16'h1A92; // and  r1,r6,r5
    imem[14] = 16'h1A93; // or   r1,r6,r5
    imem[15] = 16'hE0FF; // addi r1,r0,-1
    imem[16] = 16'hA288; // sw   r5,8(r0)
    imem[17] = 16'h8108; // lw   r2,8(r0)
    imem[18] = 16'h08B5; // funct 5 -> add r3,r2,r1
    imem[19] = 16'hC085; // beq  r0,r1,+5 (not taken)
    imem[20] = 16'hC002; // beq  r0,r0,+2 (taken)
    imem[21] = 16'hE0FF;
    imem[22] = 16'hE0FF;
    imem[23] = 16'hE007; // addi r0,r0,7
    imem[24] = 16'h0010; // add  r1,r0,r0
    imem[25] = 16'h1C08; // jr   r7
    dmem[2]   = 16'h1234;
    dstall[2] = 3;
    istall[10] = 2;

    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_dmem_we", bus.dmem_we, 0);
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_imem_addr", bus.imem_addr, 16'h0000);
    check("rst_retire", retire, 0);
    check("rst_alu", alu_result, 0);
    check("rst_dmem_addr", bus.dmem_addr, 0);
    check("rst_dmem_wdata", bus.dmem_wdata, 0);
`ifdef MIPS_MC_PERF_EN
    check("rst_instret", instret, 0);
`endif

    push_ret(16'h0002, 16'h0005, 1, 0);
    push_ret(16'h0004, 16'h000A, 1, 4);
    push_ret(16'h0010, 16'h0000, 0, 3);
    push_ret(16'h0012, 16'h0004, 1, 8);
    push_ret(16'h0014, 16'h123A, 1, 4);
    push_ret(16'h0016, 16'hEDD6, 1, 6);
    push_ret(16'h0018, 16'h0000, 1, 4);
    push_ret(16'h001A, 16'h0001, 1, 4);
    push_ret(16'h001C, 16'h0012, 1, 4);
    push_ret(16'h001E, 16'hFFFE, 1, 4);
    push_ret(16'h0020, 16'hFFFF, 1, 4);
    push_ret(16'h0022, 16'h0008, 1, 4);
    push_ret(16'h0024, 16'h0008, 1, 5);
    push_ret(16'h0026, 16'h1239, 1, 4);
    push_ret(16'h0028, 16'h0001, 1, 3);
    push_ret(16'h002E, 16'h0000, 1, 3);
    push_ret(16'h0030, 16'h0007, 1, 4);
    push_ret(16'h0032, 16'h0000, 1, 4);
    push_ret(16'h0006, 16'h0000, 0, 3);
    for (int i = 0; i < 3; i++) push_ret(16'h0006, 16'h0000, 1, 3);
    push_mem(1'b0, 16'h0004, 16'h0000, 4);
    push_mem(1'b1, 16'h0008, 16'h123A, 1);
    push_mem(1'b0, 16'h0008, 16'h0000, 1);

    sb_on = 1'b1;
    reset_n = 1'b1;
    #2;
    check("idle_imem_req", bus.imem_req, 0);
    @(posedge clk);
    #1;
    check("first_fetch_req", bus.imem_req, 1);
    check("first_fetch_addr", bus.imem_addr, 16'h0000);
    drain("prog");
    sb_on = 1'b0;

    // Abort a stalled store by reset.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    imem[0] = 16'hE185; // addi r3,r0,5
    imem[1] = 16'hA184; // sw   r3,4(r0)
    imem[2] = 16'hC07F; // beq  r0,r0,-1 (loop at 4)
    dstall[2] = 20;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      found = bus.dmem_req;
    end
    check("abort_reached_mem", found, 1);
    check("abort_store_we", bus.dmem_we, 1);
    check("abort_store_addr", bus.dmem_addr, 16'h0004);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_dmem_req", bus.dmem_req, 0);
    check("abort_dmem_we", bus.dmem_we, 0);
    check("abort_pc_out", pc_out, 16'h0000);
    check("abort_alu", alu_result, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_mem_kept", dmem[2], 16'h1234);
`ifdef MIPS_MC_PERF_EN
    check("abort_instret", instret, 0);
`endif

    // Rerun without stalls: the store now lands.
    dstall[2] = 0;
    push_ret(16'h0002, 16'h0005, 1, 0);
    push_ret(16'h0004, 16'h0004, 1, 4);
    push_ret(16'h0004, 16'h0000, 1, 3);
    push_ret(16'h0004, 16'h0000, 1, 3);
    push_mem(1'b1, 16'h0004, 16'h0005, 1);
    sb_on = 1'b1;
    ret_base = ret_cnt;
    reset_n = 1'b1;
    drain("rerun");
    sb_on = 1'b0;
    @(posedge clk);
    #1;
    check("rerun_store", dmem[2], 16'h0005);
`ifdef MIPS_MC_PERF_EN
    check("instret_count", instret, ret_cnt - ret_base);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Parametrised multi-cycle successor to the 16-bit single-cycle MIPS core. It executes the same 8-opcode, 16-bit instruction set over a configurable datapath width. Instruction and data memories sit behind separate req/ready handshake ports, so memories may stall the core. The core sits between the top-level testbench or SoC and external instruction and data memories, and exposes PC and ALU result for observation.

## Interface
- `DATA_W`, 16: datapath, register, PC and data-bus width; legal values are 16 or greater.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  clock, all state rises on posedge.
- `reset_n`  in  1  **one clock; reset is asynchronous and active-low.**
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  DATA_W  fetch byte address (= PC).
- `imem_rdata`  in  16  instruction word, sampled when `imem_req && imem_ready`.
- `imem_ready`  in  1  fetch completes this cycle.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`.
- `dmem_addr`  out  DATA_W  data byte address.
- `dmem_wdata`  out  DATA_W  store data.
- `dmem_rdata`  in  DATA_W  load data, sampled when `dmem_req && dmem_ready`.
- `dmem_ready`  in  1  data access completes this cycle.
- `pc_out`  out  DATA_W  address of the instruction in flight.
- `alu_result`  out  DATA_W  registered ALU output of the last EXEC.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired-instruction count; present only with `MIPS_MC_PERF_EN`.

## Operation
- Instruction fields: opcode [15:13], rs [12:10], rt [9:7], rd [6:4], funct [3:0], imm7 [6:0], jtarget [12:0].
- The register file holds 8 × DATA_W registers. Reading r0 returns 0. Writes to r0 are discarded.
- imm7 is sign-extended to DATA_W, except for slti, where it is zero-extended.
- Opcodes:
  - 000 R-type. funct 0 add, 1 sub, 2 and, 3 or, 4 slt (unsigned; result 1 or 0), 8 jr (PC ← rs, no register write). All other funct values execute as add. Result is written to rd.
  - 001 slti: rt ← (rs < zext(imm7)), unsigned.
  - 010 j.
  - 011 jal: r7 ← PC+2.
  - 100 lw: rt ← mem[rs + imm].
  - 101 sw: mem[rs + imm] ← rt.
  - 110 beq: taken if rs − rt == 0; target is PC+2 + (imm << 1).
  - 111 addi: rt ← rs + imm.
- Jump target for j and jal = {(PC+2)[DATA_W-1:14], jtarget, 1'b0}.
- All arithmetic is modulo 2^DATA_W, with no overflow detection.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB.
  - IDLE → FETCH unconditionally.
  - FETCH holds until `imem_ready`. The instruction register latches `imem_rdata`, then the FSM moves to DECODE.
  - DECODE latches A = reg[rs] and B = reg[rt] → EXEC.
  - EXEC latches `alu_result`, then:
    - lw or sw → MEM.
    - R-type (not jr), slti, addi → WB.
    - beq, j, jal, jr: PC updates here, jal writes r7 here, then → FETCH.
  - MEM holds until `dmem_ready`. lw → WB with the load data latched. sw → FETCH.
  - WB writes the register file and sets PC ← PC+2 → FETCH.
- PC changes only when an instruction completes. `pc_out` and `imem_addr` equal PC.
- `imem_req` = (state == FETCH). `dmem_req` = (state == MEM). `dmem_we` = MEM and opcode sw.
- Address and write-data outputs stay stable for the whole request.

## Timing
- Cycle counts assume memories with zero wait states. Each ready-low cycle adds one cycle.
  - R-type, slti, addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
- The handshake completes at the edge where req && ready are both 1. The request drops the next cycle.
- `ready` while req is 0 is ignored. Req never depends combinationally on ready.
- `retire` is registered. It is high in the first FETCH cycle of the next instruction.
- Reset values:
  - state IDLE; PC = RESET_PC, so `pc_out` = `imem_addr` = RESET_PC.
  - `imem_req`, `dmem_req`, `dmem_we` = 0.
  - `alu_result`, `dmem_addr`, `dmem_wdata` = 0.
  - `retire` = 0; all registers 0; `instret` = 0.
  - First `imem_req` is asserted in the second cycle after `reset_n` rises.
- Reset mid-operation aborts immediately and asynchronously. Req lines drop while `reset_n` is low, and no register or memory write completes.

## Configuration
- `MIPS_MC_PERF_EN` defined: the 32-bit `instret` port exists. It increments, wrapping, on every `retire` pulse.
- `MIPS_MC_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `mips_mc_pkg` holds:
  - opcode and funct localparams;
  - state enum typedef;
  - ALU-op enum (ADD, SUB, AND, OR, SLT).
- Sub-module `mips_mc_regfile`: 8 × DATA_W registers, 2 async read ports, 1 write port, cleared on reset. The ALU and FSM are inline.

## Test plan
- Reset: hold `reset_n` low 3 cycles with both readys = 1 → `imem_req`=0, `pc_out`=0x0000, `retire`=0. `imem_req`=1 with `imem_addr`=0 two cycles after release.
- Run 0xE185 (addi r3,r0,5) then 0x0DC0 (add r4,r3,r3) → `alu_result` 0x0005 then 0x000A. `retire` pulses 4 cycles apart; `pc_out` goes 0→2→4.
- Memory stall: 0x8184 (lw r3,4(r0)) with `dmem_ready` low 3 cycles and `dmem_rdata`=0x1234 → `dmem_req` held 4 cycles with `dmem_addr`=0x0004 stable. r3=0x1234 after 8 cycles total.
- Branch loop: 0xC07F at PC 6 (beq r0,r0,-1) → PC stays 0x0006 and `retire` pulses every 3 cycles.
- Jump-and-link: 0x6008 at PC 4 → PC=0x0010 and r7=0x0006 after 3 cycles. With DATA_W=32, repeat with the upper PC bits preserved.
- Abort and count: assert `reset_n` low during the MEM state of sw 0xA184 → `dmem_req` and `dmem_we` fall the same cycle and memory is unchanged. With `MIPS_MC_PERF_EN`, `instret` returns to 0 and later counts 1 per retire.
